// File: rtl/sram_pkg.sv
// Shared types and default geometry for the SRAM write-side front end.
package sram_pkg;

    localparam int SRAM_BITWIDTH = 256;
    localparam int SRAM_WIDTH    = 16;

    typedef logic [SRAM_WIDTH-1:0] word_t;
    typedef word_t [SRAM_BITWIDTH-1:0] line_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } buf_state_e;

endpackage

// File: rtl/sram_line_buf.sv
// One SRAM line buffer: lane-addressed word writes, pad-fill on close, FILL/FULL state
// and the address/last tags that travel with the line.
module sram_line_buf
    import sram_pkg::*;
#(
    parameter int               BITWIDTH = SRAM_BITWIDTH,
    parameter int               WIDTH    = SRAM_WIDTH,
    parameter logic [WIDTH-1:0] PAD      = '0,
    localparam int              LW       = $clog2(BITWIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [LW-1:0]                    wr_lane,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             wr_last,
    input  logic [WIDTH-1:0]                 wr_addr,
    input  logic                             take,
    output buf_state_e                       state,
    output logic [BITWIDTH-1:0][WIDTH-1:0]   data,
    output logic [WIDTH-1:0]                 addr,
    output logic                             last
);

    logic close;

    // A line closes on its top lane or on a frame-end word in any lane.
    assign close = wr_en && (wr_last || (wr_lane == LW'(BITWIDTH - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            // NOTE: the line storage is reset on purpose: the output must read zero after
            // reset and a discarded partial line must never leak stale lanes.
            data  <= '0;
            addr  <= '0;
            last  <= '0;
        end else begin
            // NOTE: every register here uses <= so all lanes, tags and state update
            // together from the same pre-edge values; = would make order matter.
            if (close) begin
                state <= FULL;
                addr  <= wr_addr;
                last  <= wr_last;
            end else if (take) begin
                state <= FILL;
            end

            for (int i = 0; i < BITWIDTH; i++) begin
                if (wr_en) begin
                    if (LW'(i) == wr_lane) begin
                        data[i] <= wr_data;
                    end else if (close && (LW'(i) > wr_lane)) begin
                        data[i] <= PAD;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sram_line_packer.sv
// Packs a serial WIDTH-bit word stream into BITWIDTH-lane SRAM lines with a valid/ready
// hand-off. Define PACKER_PINGPONG_EN for two line buffers; the default build has one.
module sram_line_packer
    import sram_pkg::*;
#(
    parameter int               BITWIDTH = SRAM_BITWIDTH,
    parameter int               WIDTH    = SRAM_WIDTH,
    parameter logic [WIDTH-1:0] PAD      = '0
) (
    input  logic                             CKL_i,
    input  logic                             RST_i,
    input  logic                             IN_VALID_i,
    output logic                             IN_READY_o,
    input  logic [WIDTH-1:0]                 IN_DATA_i,
    input  logic                             IN_LAST_i,
    input  logic [WIDTH-1:0]                 FRAME_BASE_i,
    output logic                             LINE_VALID_o,
    input  logic                             LINE_READY_i,
    output logic [BITWIDTH-1:0][WIDTH-1:0]   LINE_DATA_o,
    output logic [WIDTH-1:0]                 LINE_ADDR_o,
    output logic                             LINE_LAST_o
);

    localparam int LW = $clog2(BITWIDTH);
`ifdef PACKER_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic [LW-1:0]                    lane_cnt;
    logic [WIDTH-1:0]                 addr_cnt;
    logic [WIDTH-1:0]                 cur_addr;
    logic                             frame_start;
    logic                             run_q;
    logic                             accept;
    logic                             close;
    logic                             handshake;
    logic [NBUF-1:0]                  wr_en;
    logic [NBUF-1:0]                  take;
    buf_state_e                       buf_state [NBUF];
    logic [BITWIDTH-1:0][WIDTH-1:0]   buf_data  [NBUF];
    logic [WIDTH-1:0]                 buf_addr  [NBUF];
    logic                             buf_last  [NBUF];

    assign accept    = IN_VALID_i && IN_READY_o;
    assign close     = accept && (IN_LAST_i || (lane_cnt == LW'(BITWIDTH - 1)));
    assign handshake = LINE_VALID_o && LINE_READY_i;
    // A frame's first word takes its line address straight from FRAME_BASE_i.
    assign cur_addr  = frame_start ? FRAME_BASE_i : addr_cnt;

    always_ff @(posedge CKL_i) begin
        if (RST_i) begin
            lane_cnt    <= '0;
            addr_cnt    <= '0;
            frame_start <= 1'b1;
            run_q       <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                lane_cnt    <= close ? '0 : lane_cnt + 1'b1;
                addr_cnt    <= close ? cur_addr + 1'b1 : cur_addr;
                frame_start <= IN_LAST_i;
            end
        end
    end

    for (genvar b = 0; b < NBUF; b++) begin : g_buf
        sram_line_buf #(
            .BITWIDTH (BITWIDTH),
            .WIDTH    (WIDTH),
            .PAD      (PAD)
        ) u_buf (
            .clk     (CKL_i),
            .rst     (RST_i),
            .wr_en   (wr_en[b]),
            .wr_lane (lane_cnt),
            .wr_data (IN_DATA_i),
            .wr_last (IN_LAST_i),
            .wr_addr (cur_addr),
            .take    (take[b]),
            .state   (buf_state[b]),
            .data    (buf_data[b]),
            .addr    (buf_addr[b]),
            .last    (buf_last[b])
        );
    end

`ifdef PACKER_PINGPONG_EN
    logic wr_sel;
    logic rd_sel;

    // Buffers fill and drain in strict alternation, so presentation follows close order.
    always_ff @(posedge CKL_i) begin
        if (RST_i) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (close) begin
                wr_sel <= ~wr_sel;
            end
            if (handshake) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    assign wr_en        = {accept && wr_sel, accept && !wr_sel};
    assign take         = {handshake && rd_sel, handshake && !rd_sel};
    assign IN_READY_o   = run_q && (buf_state[wr_sel] == FILL);
    assign LINE_VALID_o = (buf_state[rd_sel] == FULL);
    assign LINE_DATA_o  = buf_data[rd_sel];
    assign LINE_ADDR_o  = buf_addr[rd_sel];
    assign LINE_LAST_o  = buf_last[rd_sel];
`else
    assign wr_en        = accept;
    assign take         = handshake;
    assign IN_READY_o   = run_q && (buf_state[0] == FILL);
    assign LINE_VALID_o = (buf_state[0] == FULL);
    assign LINE_DATA_o  = buf_data[0];
    assign LINE_ADDR_o  = buf_addr[0];
    assign LINE_LAST_o  = buf_last[0];
`endif

endmodule

// File: tb/tb_sram_line_packer.sv
// Bench for sram_line_packer (BITWIDTH=4, PAD=0xDEAD): directed cases plus random stalls,
// scored every cycle against a queue-based line model.
module tb_sram_line_packer;
    import sram_pkg::*;

    localparam int          BW   = 4;
    localparam int          W    = 16;
    localparam logic [15:0] PADV = 16'hDEAD;
`ifdef PACKER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [63:0] data;
        logic [15:0] addr;
        logic        last;
    } line_s;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    word_t                  in_data = '0;
    logic                   in_last = 1'b0;
    word_t                  frame_base = '0;
    logic                   line_valid;
    logic                   line_ready = 1'b0;
    logic [BW-1:0][W-1:0]   line_data;
    word_t                  line_addr;
    logic                   line_last;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    rdy_mode = 1'b0;
    bit    rdy_fixed = 1'b0;
    bit    exp_ready;
    bit    exp_valid;
    bit    m_run = 1'b0;
    bit    m_frame_start = 1'b1;
    word_t m_next_addr = '0;
    word_t cur_words[$];
    line_s pend_q[$];
    line_s done_q[$];

    always #5 clk = ~clk;

    sram_line_packer #(
        .BITWIDTH (BW),
        .WIDTH    (W),
        .PAD      (PADV)
    ) dut (
        .CKL_i        (clk),
        .RST_i        (rst),
        .IN_VALID_i   (in_valid),
        .IN_READY_o   (in_ready),
        .IN_DATA_i    (in_data),
        .IN_LAST_i    (in_last),
        .FRAME_BASE_i (frame_base),
        .LINE_VALID_o (line_valid),
        .LINE_READY_i (line_ready),
        .LINE_DATA_o  (line_data),
        .LINE_ADDR_o  (line_addr),
        .LINE_LAST_o  (line_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic line_s build_line(input word_t base, input bit last);
        line_s l;
        l.data = '0;
        for (int k = 0; k < BW; k++) begin
            l.data[16*k +: 16] = (k < cur_words.size()) ? cur_words[k] : PADV;
        end
        l.addr = base;
        l.last = last;
        return l;
    endfunction

    // Reference model: lines are built from accepted words; pend_q holds closed, unsent lines.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_ready = m_run && (pend_q.size() < CAP);
            exp_valid = (pend_q.size() != 0);
            check("in_ready", in_ready, exp_ready);
            check("line_valid", line_valid, exp_valid);
            if (exp_valid) begin
                check("line_data", line_data, pend_q[0].data);
                check("line_addr", line_addr, pend_q[0].addr);
                check("line_last", line_last, pend_q[0].last);
            end
            if (rst) begin
                pend_q.delete();
                cur_words.delete();
                m_run = 1'b0;
                m_frame_start = 1'b1;
                m_next_addr = '0;
            end else begin
                m_run = 1'b1;
                if (exp_valid && line_ready) begin
                    done_q.push_back(pend_q[0]);
                    void'(pend_q.pop_front());
                end
                if (in_valid && exp_ready) begin
                    if (m_frame_start) m_next_addr = frame_base;
                    m_frame_start = in_last;
                    cur_words.push_back(in_data);
                    if (in_last || (cur_words.size() == BW)) begin
                        pend_q.push_back(build_line(m_next_addr, in_last));
                        m_next_addr = m_next_addr + 16'd1;
                        cur_words.delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            line_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input word_t d, input bit last, input word_t base);
        int n = 0;
        bit ok = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_last    = last;
        frame_base = base;
        do begin
            @(negedge clk);
            ok = in_ready;
            to_drive();
            n++;
        end while (!ok && (n < 200));
        if (!ok) check("send_timeout", 0, 1);
        in_valid   = 1'b0;
        in_data    = word_t'($urandom);
        in_last    = 1'($urandom);
        frame_base = word_t'($urandom);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((pend_q.size() != 0) && (n < lim)) begin
            to_drive();
            n++;
        end
        check("drain_done", pend_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) to_drive();
        rst = 1'b0;
        to_drive();
    endtask

    initial begin
        to_drive();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_line_valid", line_valid, 0);
        check("rst_line_data", line_data, 0);
        check("rst_line_addr", line_addr, 0);
        check("rst_line_last", line_last, 0);
        to_drive();
        rst = 1'b0;
        to_drive();
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        to_drive();

        // Full line with last on lane 3.
        rdy_fixed = 1'b1;
        done_q.delete();
        for (int i = 1; i <= 4; i++) send(word_t'(i), i == 4, 16'h0010);
        @(negedge clk);
        check("t1_latency_valid", line_valid, 1);
        check("t1_addr_now", line_addr, 16'h0010);
        to_drive();
        drain(50);
        check("t1_count", done_q.size(), 1);
        if (done_q.size() == 1) begin
            check("t1_data", done_q[0].data, 64'h0004_0003_0002_0001);
            check("t1_addr", done_q[0].addr, 16'h0010);
            check("t1_last", done_q[0].last, 1);
        end

        // Short frames padded, new base per frame.
        done_q.delete();
        send(16'd7, 1'b0, 16'h0030);
        send(16'd8, 1'b1, 16'h0030);
        send(16'd5, 1'b1, 16'h0050);
        drain(50);
        check("t2_count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            check("t2_data0", done_q[0].data, 64'hDEAD_DEAD_0008_0007);
            check("t2_addr0", done_q[0].addr, 16'h0030);
            check("t2_last0", done_q[0].last, 1);
            check("t2_data1", done_q[1].data, 64'hDEAD_DEAD_DEAD_0005);
            check("t2_addr1", done_q[1].addr, 16'h0050);
        end

        // Address wrap from 0xFFFF.
        done_q.delete();
        for (int i = 0; i < 12; i++) send(word_t'(16'h0100 + i), i == 11, 16'hFFFF);
        drain(50);
        check("t3_count", done_q.size(), 3);
        if (done_q.size() == 3) begin
            check("t3_addr0", done_q[0].addr, 16'hFFFF);
            check("t3_addr1", done_q[1].addr, 16'h0000);
            check("t3_addr2", done_q[2].addr, 16'h0001);
            check("t3_last0", done_q[0].last, 0);
            check("t3_last1", done_q[1].last, 0);
            check("t3_last2", done_q[2].last, 1);
            check("t3_data0", done_q[0].data, 64'h0103_0102_0101_0100);
            check("t3_data2", done_q[2].data, 64'h010B_010A_0109_0108);
        end

        // Output stall for 10 cycles.
        done_q.delete();
        rdy_fixed = 1'b0;
        to_drive();
        for (int i = 1; i <= 4; i++) send(word_t'(16'h0200 + i), i == 4, 16'h0070);
`ifdef PACKER_PINGPONG_EN
        for (int i = 5; i <= 8; i++) send(word_t'(16'h0200 + i), i == 8, 16'h0080);
`endif
        repeat (10) begin
            @(negedge clk);
            check("t4_valid", line_valid, 1);
            check("t4_data", line_data, 64'h0204_0203_0202_0201);
            check("t4_addr", line_addr, 16'h0070);
            check("t4_last", line_last, 1);
            check("t4_in_ready", in_ready, 0);
        end
        to_drive();
        rdy_fixed = 1'b1;
        drain(50);
        check("t4_count", done_q.size(), CAP);

        // Reset while a line is pending and again mid-line.
        rdy_fixed = 1'b0;
        to_drive();
        for (int i = 1; i <= 4; i++) send(word_t'(16'h0300 + i), i == 4, 16'h0090);
        pulse_reset();
        @(negedge clk);
        check("t5_valid_cleared", line_valid, 0);
        check("t5_data_cleared", line_data, 0);
        check("t5_addr_cleared", line_addr, 0);
        to_drive();
        send(16'd1, 1'b0, 16'h0040);
        send(16'd2, 1'b0, 16'h0040);
        pulse_reset();
        done_q.delete();
        rdy_fixed = 1'b1;
        for (int i = 9; i <= 12; i++) send(word_t'(i), i == 12, 16'h0020);
        drain(50);
        check("t5_count", done_q.size(), 1);
        if (done_q.size() == 1) begin
            check("t5_data", done_q[0].data, 64'h000C_000B_000A_0009);
            check("t5_addr", done_q[0].addr, 16'h0020);
            check("t5_last", done_q[0].last, 1);
        end

        // Random input gaps and output stalls.
        done_q.delete();
        rdy_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) to_drive();
            send(word_t'($urandom), (i == 999) || ($urandom_range(0, 5) == 0), word_t'($urandom));
        end
        drain(400);
        rdy_mode = 1'b0;
        check("t6_lines_min", done_q.size() >= 250, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_line_packer.md
# sram_line_packer

Write-side front end for `sram_controler`. It collects a serial stream of WIDTH-bit words into one BITWIDTH-lane SRAM line and generates the line address. It then hands the line and its address to the controller's `SRAM_i`/`ADDR_in` side through a valid/ready handshake. A frame-end marker flushes a partial line, with the unused lanes padded.

## Interface
Parameters:
- `BITWIDTH`, 256: lanes per SRAM line; must be a power of two, ≥2.
- `WIDTH`, 16: bits per word; also the line-address width.
- `PAD`, 0: WIDTH-bit value written into lanes left empty by a frame-end flush.

Ports:
- `CKL_i`  in  1  single clock; all logic on its rising edge.
- `RST_i`  in  1  reset; synchronous, active-high.
- `IN_VALID_i`  in  1  input word valid.
- `IN_READY_o`  out  1  packer can accept a word this cycle.
- `IN_DATA_i`  in  WIDTH  input word.
- `IN_LAST_i`  in  1  the accepted word is the last word of its frame.
- `FRAME_BASE_i`  in  WIDTH  line address of the frame's first line; sampled with the frame's first accepted word.
- `LINE_VALID_o`  out  1  a complete line is presented.
- `LINE_READY_i`  in  1  controller takes the line.
- `LINE_DATA_o`  out  [BITWIDTH-1:0][WIDTH-1:0]  line; drives controller `SRAM_i`.
- `LINE_ADDR_o`  out  WIDTH  line address; drives controller `ADDR_in`.
- `LINE_LAST_o`  out  1  line is the final line of its frame.

## Operation
- A word is accepted when `IN_VALID_i && IN_READY_o`. The k-th accepted word of a line goes to lane k (`LINE_DATA_o[k]`); `lane_cnt` counts 0..BITWIDTH-1.
- The first word of a frame (after reset or after an `IN_LAST_i` word) loads `addr_cnt <= FRAME_BASE_i`. Each emitted line takes `addr_cnt`, then `addr_cnt` increments modulo 2^WIDTH (0xFFFF wraps to 0x0000).
- Line close happens in either of two cases:
  - The word in lane BITWIDTH-1 is accepted. `LINE_LAST_o` is set to that word's `IN_LAST_i`.
  - `IN_LAST_i` is accepted in lane j<BITWIDTH-1. Lanes j+1..BITWIDTH-1 are written with `PAD` and `LINE_LAST_o`=1.
- In both cases `lane_cnt` returns to 0.
- State machine, per buffer:
  - FILL → FULL on line close.
  - FULL → FILL on `LINE_VALID_o && LINE_READY_i`.
- `LINE_DATA_o`, `LINE_ADDR_o` and `LINE_LAST_o` hold stable while `LINE_VALID_o && !LINE_READY_i`. `LINE_VALID_o` never drops without a handshake.
- A word is never accepted unless a buffer is in FILL.
- `LINE_READY_i` is ignored while `LINE_VALID_o`=0.
- `IN_DATA_i`, `IN_LAST_i` and `FRAME_BASE_i` are ignored on cycles without acceptance.
- Reset, including mid-line or mid-handshake:
  - Discard the partial line and any pending line.
  - `lane_cnt`=0, `addr_cnt`=0, all buffers to FILL.
  - The next accepted word is treated as a frame start.

## Timing
- Reset values:
  - `IN_READY_o`=1 on the cycle after reset deasserts; 0 while `RST_i` is high.
  - `LINE_VALID_o`=0, `LINE_DATA_o`=0, `LINE_ADDR_o`=0, `LINE_LAST_o`=0.
- Latency: closing word accepted at edge t → `LINE_VALID_o`=1 during cycle t+1.
- Padding is applied in the same edge as the close; no extra cycles.
- `IN_READY_o` is a registered/state-derived output with no combinational path from `IN_VALID_i`.
- `LINE_VALID_o` has no combinational path from any input.
- Minimum line period is BITWIDTH cycles (one word per cycle).

## Configuration
- `PACKER_PINGPONG_EN` defined:
  - Two line buffers. One fills while the other is FULL/presented.
  - `IN_READY_o`=0 only when both buffers are FULL.
  - If the presented line handshakes at edge t while the other buffer is FULL, the other line is presented in cycle t+1 with `LINE_VALID_o` held high.
  - A line closing on the same edge as a handshake is legal; lines are presented in close order.
- Not defined:
  - Single buffer. `IN_READY_o` = !FULL.
  - Handshake at edge t → `IN_READY_o`=1 in cycle t+1.
  - Input stalls for the whole time a line is pending.

## Structure
- Shared package `sram_pkg` holds:
  - the `BITWIDTH`/`WIDTH` defaults;
  - `typedef logic [WIDTH-1:0] word_t`;
  - `typedef word_t [BITWIDTH-1:0] line_t`;
  - enum `buf_state_e {FILL, FULL}`.
- One sub-module, `sram_line_buf`. It holds one `line_t` register, lane write enable, pad-fill on close, its state, and its `addr`/`last` tags. It is instantiated once, or twice under `PACKER_PINGPONG_EN`.
- The top level holds `lane_cnt`, `addr_cnt`, buffer select and output mux.

## Test plan
- BITWIDTH=4, base 0x0010, words 1,2,3,4 with `IN_LAST_i` on 4, `LINE_READY_i`=1 → one line {4,3,2,1} (lane3..0) at addr 0x0010, `LINE_LAST_o`=1, valid exactly one cycle after word 4.
- BITWIDTH=4, PAD=0xDEAD, frame 7,8 with last on 8 → line {DEAD,DEAD,8,7}, `LINE_LAST_o`=1, next frame restarts at a new `FRAME_BASE_i`.
- Base 0xFFFF, 12 words, BITWIDTH=4 → three lines at addresses 0xFFFF, 0x0000, 0x0001; `LINE_LAST_o` only on the third line.
- `LINE_READY_i` held low 10 cycles after a line closes → outputs stable all 10 cycles.
  - Single-buffer build: `IN_READY_o`=0 throughout.
  - Ping-pong build: 4 more words accepted, then `IN_READY_o`=0; two back-to-back lines on release.
- `RST_i` pulsed after 2 of 4 words, then words 9,10,11,12 (last on 12) with base 0x0020 → single line {12,11,10,9} at 0x0020; no stale lanes or lines.
- Random `IN_VALID_i`/`LINE_READY_i` stalls over 1000 words → scoreboard matches order, addresses and padding, with no drop or duplicate.
